// File: rtl/seq_mul_div_if.sv
// Handshake and result bundle for the sequential multiply/divide unit.
//   start, op           request strobe and operation select (0 = mul, 1 = div)
//   operand_a           multiplicand / dividend (Y register), signed
//   operand_b           multiplier / divisor (bus), signed
//   busy, done          unit is iterating / one-cycle result-valid pulse
//   div_by_zero         divide with a zero divisor, raised together with done
//   z_hi, z_lo          mul: product high/low halves; div: remainder/quotient
// The master modport drives requests; the slave modport is the unit itself.
interface seq_mul_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] z_hi;
  logic [WIDTH-1:0] z_lo;

  modport master (
    output start, op, operand_a, operand_b,
    input  busy, done, div_by_zero, z_hi, z_lo
  );

  modport slave (
    input  start, op, operand_a, operand_b,
    output busy, done, div_by_zero, z_hi, z_lo
  );
endinterface

// File: rtl/seq_mul_div.sv
// Multi-cycle signed multiply/divide unit for MUL and DIV instructions.
// Multiply is radix-2 Booth and divide is restoring division on magnitudes,
// both retiring one iteration per clock (WIDTH iterations), followed by a
// fix-up cycle that writes the 2*WIDTH-bit result into z_hi/z_lo.
// Ports:
//   clk   system clock, rising edge
//   clr   asynchronous active-high reset; aborts any operation in flight
//   bus   seq_mul_div_if slave: start/op/operand_a/operand_b in,
//         busy/done/div_by_zero/z_hi/z_lo out
module seq_mul_div #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          clr,
  seq_mul_div_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t state, state_next;

  logic [CW-1:0]           count;
  logic                    op_q;
  logic                    neg_q;
  logic                    neg_r;
  logic                    q_1;
  logic                    dbz;
  logic signed [WIDTH:0]   acc;      // Booth accumulator / division partial remainder
  logic signed [WIDTH:0]   m;        // multiplicand (sign-extended) or |divisor|
  logic [WIDTH-1:0]        qreg;     // multiplier bits / dividend-then-quotient bits
  logic [WIDTH-1:0]        z_hi;
  logic [WIDTH-1:0]        z_lo;

  logic                    accept;
  logic                    div_zero_req;
  logic signed [WIDTH:0]   booth_sum;
  logic [WIDTH:0]          rem_sh;
  logic [WIDTH:0]          trial;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    // Two's-complement negation of INT_MIN yields INT_MIN, which read as
    // unsigned is exactly its magnitude.
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x,
                                                 input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  assign accept       = (state == IDLE) && bus.start;
  assign div_zero_req = bus.op && (bus.operand_b == '0);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = div_zero_req ? DONE : RUN;
      RUN:     if (count == '0) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One iteration of each algorithm, evaluated from the current registers.
  always_comb begin
    booth_sum = acc;
    case ({qreg[0], q_1})
      2'b01:   booth_sum = acc + m;
      2'b10:   booth_sum = acc - m;
      default: booth_sum = acc;
    endcase
    rem_sh = {acc[WIDTH-1:0], qreg[WIDTH-1]};
    trial  = rem_sh - $unsigned(m);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count <= '0;
      op_q  <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      q_1   <= 1'b0;
      dbz   <= 1'b0;
      acc   <= '0;
      m     <= '0;
      qreg  <= '0;
      z_hi  <= '0;
      z_lo  <= '0;
    end else begin
      if (accept) begin
        dbz <= div_zero_req;
        if (div_zero_req) begin
          z_hi <= bus.operand_a;
          z_lo <= '1;
        end else begin
          op_q  <= bus.op;
          count <= CW'(WIDTH - 1);
          acc   <= '0;
          q_1   <= 1'b0;
          neg_q <= bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1];
          neg_r <= bus.operand_a[WIDTH-1];
          if (bus.op) begin
            m    <= {1'b0, mag(bus.operand_b)};
            qreg <= mag(bus.operand_a);
          end else begin
            m    <= {bus.operand_a[WIDTH-1], bus.operand_a};
            qreg <= bus.operand_b;
          end
        end
      end else if (state == RUN) begin
        count <= count - CW'(1);
        if (!op_q) begin
          // Arithmetic shift of {acc, qreg, q_1} right by one.
          acc  <= booth_sum >>> 1;
          qreg <= {booth_sum[0], qreg[WIDTH-1:1]};
          q_1  <= qreg[0];
        end else if (!trial[WIDTH]) begin
          acc  <= $signed(trial);
          qreg <= {qreg[WIDTH-2:0], 1'b1};
        end else begin
          acc  <= $signed(rem_sh);
          qreg <= {qreg[WIDTH-2:0], 1'b0};
        end
      end else if (state == FIX) begin
        if (!op_q) begin
          z_hi <= acc[WIDTH-1:0];
          z_lo <= qreg;
        end else begin
          // Quotient truncates toward zero; remainder follows the dividend.
          z_hi <= cond_neg(acc[WIDTH-1:0], neg_r);
          z_lo <= cond_neg(qreg, neg_q);
        end
      end
    end
  end

  assign bus.busy        = (state == RUN) || (state == FIX);
  assign bus.done        = (state == DONE);
  assign bus.div_by_zero = dbz;
  assign bus.z_hi        = z_hi;
  assign bus.z_lo        = z_lo;

endmodule
